pattern_capture_sync: RTL

//  Clocked, parametrised successor to the all-ones capture logic. Synchronises an asynchronous WIDTH-bit
//  bus and detects when it equals a match pattern. On a selectable rising/falling/both transition of that

---
 rtl/pattern_capture_sync.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pattern_capture_sync.sv
// rtl/pattern_capture_sync.sv - synchronised pattern-match edge capture into a first-word fall-through FIFO
// Optional per-entry timestamps and the cap_ts port are enabled by defining CAPTURE_TIMESTAMP_EN.
module pattern_capture_sync #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] MATCH       = {WIDTH{1'b1}},
  parameter int               DEPTH       = 4,
  parameter int               SYNC_STAGES = 2
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  parameter int               TS_WIDTH    = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           q_in,
  input  logic [1:0]                 edge_mode,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic                       match_flag,
  output logic                       cap_valid,
  output logic [WIDTH-1:0]           cap_data,
  output logic [$clog2(DEPTH+1)-1:0] cap_count,
  output logic                       overflow
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]        cap_ts
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] qs;
  logic             match;
  logic             match_flag_q;
  logic             rise;
  logic             fall;
  logic             events_en;
  logic             cap_evt;

  logic [WW-1:0]    warm_q;
  logic [WW-1:0]    warm_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= q_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign qs    = sync_q[SYNC_STAGES-1];
  assign match = (qs == MATCH);
  assign rise  = match & ~match_flag_q;
  assign fall  = ~match & match_flag_q;

  // Warm-up masks the spurious edges the sync chain produces while it fills after reset.
  assign events_en = (warm_q == WARM_DONE);
  assign warm_d    = events_en ? warm_q : warm_q + WW'(1);

  always_comb begin
    cap_evt = 1'b0;
    case (edge_mode)
      2'b00:   cap_evt = fall;
      2'b01:   cap_evt = rise;
      2'b10:   cap_evt = rise | fall;
      default: cap_evt = 1'b0;
    endcase
    cap_evt = cap_evt & events_en;
  end

  // A pop on a full FIFO frees the slot the coincident write needs; an empty FIFO never pops.
  assign full  = (count_q == FULL_CNT);
  assign pop   = rd_en & (count_q != '0);
  assign wr_en = cap_evt & (~full | pop) & ~reset;
  assign drop  = cap_evt & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_flag_q <= 1'b0;
      warm_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      match_flag_q <= match;
      warm_q       <= warm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= qs;
  end

  assign match_flag = match_flag_q;
  assign cap_valid  = (count_q != '0);
  assign cap_data   = cap_valid ? mem_q[rd_ptr_q] : '0;
  assign cap_count  = count_q;
  assign overflow   = ovf_q;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem_q[wr_ptr_q] <= ts_q;
  end

  assign cap_ts = cap_valid ? ts_mem_q[rd_ptr_q] : '0;
`endif

endmodule
